shift_sequencer: RTL and testbench

//  Iterative shift unit for the ALU: one 1-bit shift stage reused over several cycles.
//  - Captures an operand, shift amount and shift kind on a start pulse.
//  - Shifts one bit per clock.
//  - Presents a registered result with a one-cycle done pulse.
//  - Replaces the wide combinational shifter where area beats latency.

---
 rtl/shift_sequencer_if.sv | 28 ++
 rtl/shift_sequencer.sv | 95 +++++++++
 tb/tb_shift_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer_if
// Brief    : Request/result bundle between the ALU and the iterative shifter.
// Revision : 1.0
// ============================================================================
interface shift_sequencer_if #(
    parameter int N = 4
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] aIn;
    logic [N-1:0] shamt;
    logic         busy;
    logic         done;
    logic [N-1:0] bOut;

    modport master (
        output start, op, aIn, shamt,
        input  busy, done, bOut
    );

    modport slave (
        input  start, op, aIn, shamt,
        output busy, done, bOut
    );
endinterface
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Brief    : Multi-cycle shifter reusing one 1-bit stage; SLL/SRL/SRA/pass.
// Revision : 1.0
// ============================================================================
module shift_sequencer #(
    parameter int N = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    shift_sequencer_if.slave    bus
);
    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0]  C_N_SH  = N'(N);
    localparam logic [CW-1:0] C_N_CNT = CW'(N);
    localparam logic [1:0]    C_SLL   = 2'b00;
    localparam logic [1:0]    C_SRL   = 2'b01;
    localparam logic [1:0]    C_SRA   = 2'b10;
    localparam logic [1:0]    C_PASS  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_q;
    logic [N-1:0]  work_q;
    logic [1:0]    kind_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  bout_q;

    logic [N-1:0]  shift_d;
    logic [CW-1:0] cnt_d;

    always_comb begin
        shift_d = work_q;
        case (kind_q)
            C_SLL:   shift_d = {work_q[N-2:0], 1'b0};
            C_SRL:   shift_d = {1'b0, work_q[N-1:1]};
            C_SRA:   shift_d = {work_q[N-1], work_q[N-1:1]};
            default: shift_d = work_q;
        endcase
    end

    // Full-width compare so large shamt values saturate instead of aliasing.
    always_comb begin
        cnt_d = '0;
        if (bus.op != C_PASS) begin
            cnt_d = (bus.shamt >= C_N_SH) ? C_N_CNT : bus.shamt[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            kind_q  <= '0;
            cnt_q   <= '0;
            bout_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        work_q  <= bus.aIn;
                        kind_q  <= bus.op;
                        cnt_q   <= cnt_d;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q != '0) begin
                        work_q <= shift_d;
                        cnt_q  <= cnt_q - CW'(1);
                    end else begin
                        bout_q  <= work_q;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
    assign bus.bOut = bout_q;
endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Brief    : Scoreboard bench for shift_sequencer (N=4).
// Revision : 1.0
// ============================================================================
module tb_shift_sequencer;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [N-1:0] exp_q[$];

    shift_sequencer_if #(.N(N)) bus ();

    shift_sequencer #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Result scoreboard: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_done: bOut=%b with no expected result queued", bus.bOut);
            end else begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                if (bus.bOut !== e) begin
                    errors++;
                    $display("FAIL result: bOut=%b expected=%b", bus.bOut, e);
                end
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] s,
                          input logic [N-1:0] exp_b, input int exp_lat, input bit noisy,
                          input string name);
        int lat;
        bit seen;
        exp_q.push_back(exp_b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.aIn   = a;
        bus.shamt = s;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (noisy) begin
                bus.aIn   = '1;
                bus.op    = 2'($urandom_range(0, 3));
                bus.shamt = N'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_busy: busy=%b expected=1 at cycle %0d", name, bus.busy, lat);
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (!seen || lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got=%0d (done_seen=%0d) expected=%0d", name, lat, seen, exp_lat);
            if (!seen && exp_q.size() > 0) void'(exp_q.pop_back());
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_done: busy=%b expected=1", name, bus.busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: done=%b busy=%b expected done=0 busy=0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.aIn   = '0;
        bus.shamt = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bOut !== 4'b0000) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b bOut=%b expected 0/0/0000", bus.busy, bus.done, bus.bOut);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_op(2'b00, 4'b0011, 4'd2, 4'b1100, 4, 1'b0, "sll2");
        run_op(2'b10, 4'b1000, 4'd1, 4'b1100, 3, 1'b0, "sra1");
        run_op(2'b01, 4'b1000, 4'd1, 4'b0100, 3, 1'b0, "srl1");
    endtask

    task automatic test_saturation();
        run_op(2'b01, 4'b1111, 4'd5,  4'b0000, 6, 1'b0, "srl_sat");
        run_op(2'b10, 4'b1010, 4'd15, 4'b1111, 6, 1'b0, "sra_sat");
        run_op(2'b00, 4'b0001, 4'b1000, 4'b0000, 6, 1'b0, "sll_sh8");
        run_op(2'b10, 4'b0110, 4'd4,  4'b0000, 6, 1'b0, "sra_pos4");
    endtask

    task automatic test_zero_and_pass();
        run_op(2'b00, 4'b0101, 4'd0, 4'b0101, 2, 1'b0, "sll0");
        run_op(2'b11, 4'b1001, 4'd3, 4'b1001, 2, 1'b0, "pass");
    endtask

    task automatic test_busy_ignore();
        run_op(2'b00, 4'b0001, 4'd3, 4'b1000, 5, 1'b1, "ignore");
    endtask

    task automatic test_back_to_back();
        run_op(2'b10, 4'b1001, 4'd2, 4'b1110, 4, 1'b0, "b2b_a");
        run_op(2'b00, 4'b1011, 4'd1, 4'b0110, 3, 1'b0, "b2b_b");
    endtask

    task automatic test_mid_reset();
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.aIn   = 4'b0001;
        bus.shamt = 4'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bOut !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b bOut=%b expected 0/0/0000", bus.busy, bus.done, bus.bOut);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_idle: done=%b busy=%b expected 0/0 at cycle %0d", bus.done, bus.busy, i);
            end
        end
        run_op(2'b00, 4'b0011, 4'd1, 4'b0110, 3, 1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_zero_and_pass();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never produced", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
